// File: rtl/ad_weight_proc.sv
// Load-cell weight pipeline: block average, tare subtract, scale, clamp.
// Optional steady-reading detector enabled by defining STABLE_DET_EN.
module ad_weight_proc #(
  parameter int unsigned AVG_LOG2    = 3,
  parameter logic [15:0] SCALE_MUL   = 16'd1000,
  parameter int unsigned SCALE_SHIFT = 16,
  parameter int unsigned W_OUT       = 16,
  parameter int unsigned STAB_TOL    = 4,
  parameter int unsigned STAB_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      ad_data,
  input  logic             ad_valid,
  input  logic             tare_req,
  output logic             tare_busy,
  output logic [W_OUT-1:0] weight,
  output logic             weight_valid,
  output logic             weight_neg,
  output logic             weight_stable
);

  localparam int unsigned AccW  = 24 + AVG_LOG2;
  localparam int unsigned ProdW = 42;
  localparam logic signed [ProdW-1:0] MulExt = ProdW'(SCALE_MUL);

  typedef enum logic [1:0] {StAcc, StCalc, StMul, StOut} state_e;

  state_e                  state_q, state_d;
  logic signed [AccW-1:0]  acc_q, acc_d, sum;
  logic [AVG_LOG2-1:0]     cnt_q, cnt_d;
  logic signed [23:0]      avg_q, avg_d, tare_q, tare_d;
  logic                    tare_pend_q, tare_pend_d;
  logic                    blk_tare_q, blk_tare_d;
  logic signed [25:0]      net_q, net_d;
  logic signed [ProdW-1:0] res_q, res_d, prod;
  logic [W_OUT-1:0]        weight_q, weight_d;
  logic                    valid_q, valid_d, neg_q, neg_d;
  logic                    last_sample, tare_load;

  assign sum         = acc_q + {{AVG_LOG2{ad_data[23]}}, ad_data};
  assign last_sample = ad_valid && (state_q == StAcc) && (&cnt_q);
  assign tare_load   = (state_q == StCalc) && blk_tare_q;
  assign prod        = $signed({{16{net_q[25]}}, net_q}) * MulExt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StAcc;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (last_sample) state_d = StCalc;
      StCalc:  state_d = StMul;
      StMul:   state_d = StOut;
      StOut:   state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // Datapath and output next-state
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    tare_d      = tare_q;
    tare_pend_d = tare_pend_q;
    blk_tare_d  = blk_tare_q;
    net_d       = net_q;
    res_d       = res_q;
    weight_d    = weight_q;
    neg_d       = neg_q;
    valid_d     = 1'b0;

    // Samples arriving outside ACC start the next block; only ACC can complete one.
    if (ad_valid) begin
      if (last_sample) begin
        acc_d      = '0;
        cnt_d      = '0;
        avg_d      = sum[AccW-1:AVG_LOG2];
        blk_tare_d = tare_pend_q;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + AVG_LOG2'(1);
      end
    end

    if (tare_req && !tare_pend_q) tare_pend_d = 1'b1;

    unique case (state_q)
      StCalc: begin
        if (blk_tare_q) begin
          tare_d      = avg_q;
          tare_pend_d = 1'b0;
          net_d       = '0;
        end else begin
          net_d = {{2{avg_q[23]}}, avg_q} - {{2{tare_q[23]}}, tare_q};
        end
      end
      StMul: res_d = prod >>> SCALE_SHIFT;
      StOut: begin
        valid_d = 1'b1;
        if (res_q[ProdW-1]) begin
          weight_d = '0;
          neg_d    = 1'b1;
        end else if (|res_q[ProdW-1:W_OUT]) begin
          weight_d = '1;
          neg_d    = 1'b0;
        end else begin
          weight_d = res_q[W_OUT-1:0];
          neg_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      tare_q      <= '0;
      tare_pend_q <= 1'b0;
      blk_tare_q  <= 1'b0;
      net_q       <= '0;
      res_q       <= '0;
      weight_q    <= '0;
      neg_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      tare_q      <= tare_d;
      tare_pend_q <= tare_pend_d;
      blk_tare_q  <= blk_tare_d;
      net_q       <= net_d;
      res_q       <= res_d;
      weight_q    <= weight_d;
      neg_q       <= neg_d;
      valid_q     <= valid_d;
    end
  end

  assign tare_busy    = tare_pend_q;
  assign weight       = weight_q;
  assign weight_valid = valid_q;
  assign weight_neg   = neg_q;

`ifdef STABLE_DET_EN
  localparam int unsigned ScW = $clog2(STAB_CNT + 1);

  logic [ScW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [W_OUT-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d, stable_q, stable_d;
  logic [W_OUT:0]   diff, mag;

  always_comb begin
    diff       = {1'b0, weight_d} - {1'b0, prev_q};
    mag        = diff[W_OUT] ? -diff : diff;
    stab_cnt_d = stab_cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    stable_d   = stable_q;
    // A fresh tare makes the next weight the first of a new sequence.
    if (tare_load) prev_vld_d = 1'b0;
    if (state_q == StOut) begin
      prev_d     = weight_d;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (mag <= (W_OUT + 1)'(STAB_TOL))) begin
        if (stab_cnt_q < ScW'(STAB_CNT)) stab_cnt_d = stab_cnt_q + ScW'(1);
      end else begin
        stab_cnt_d = '0;
      end
      stable_d = (stab_cnt_d == ScW'(STAB_CNT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt_q <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      stable_q   <= 1'b0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      stable_q   <= stable_d;
    end
  end

  assign weight_stable = stable_q;
`else
  assign weight_stable = 1'b0;
`endif

endmodule

// File: tb/tb_ad_weight_proc.sv
// Scoreboard bench for ad_weight_proc with unity gain and 8-sample blocks.
module tb_ad_weight_proc;

`ifdef STABLE_DET_EN
  localparam bit StabEn = 1'b1;
`else
  localparam bit StabEn = 1'b0;
`endif

  typedef struct {
    logic [15:0] w;
    logic        neg;
    logic        st;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] ad_data = '0;
  logic        ad_valid = 1'b0;
  logic        tare_req = 1'b0;
  logic        tare_busy;
  logic [15:0] weight;
  logic        weight_valid;
  logic        weight_neg;
  logic        weight_stable;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  int unsigned cyc  = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  ad_weight_proc #(
    .AVG_LOG2   (3),
    .SCALE_MUL  (16'd1),
    .SCALE_SHIFT(0),
    .W_OUT      (16),
    .STAB_TOL   (4),
    .STAB_CNT   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ad_data      (ad_data),
    .ad_valid     (ad_valid),
    .tare_req     (tare_req),
    .tare_busy    (tare_busy),
    .weight       (weight),
    .weight_valid (weight_valid),
    .weight_neg   (weight_neg),
    .weight_stable(weight_stable)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every weight_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (weight_valid) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_output: got weight=%0d neg=%0b, required no output",
                 weight, weight_neg);
      end else begin
        mon_e = exp_q.pop_front();
        vecs += 4;
        if (weight !== mon_e.w) begin
          errs++;
          $display("FAIL weight: got %0d, required %0d", weight, mon_e.w);
        end
        if (weight_neg !== mon_e.neg) begin
          errs++;
          $display("FAIL weight_neg: got %0b, required %0b", weight_neg, mon_e.neg);
        end
        if (weight_stable !== mon_e.st) begin
          errs++;
          $display("FAIL weight_stable: got %0b, required %0b", weight_stable, mon_e.st);
        end
        if (cyc !== mon_e.cyc) begin
          errs++;
          $display("FAIL latency: got cycle %0d, required cycle %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    ad_valid = 1'b0;
    tare_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive n samples of value d, 6 cycles apart; optionally expect an output on the last one.
  task automatic drive(input logic [23:0] d, input int n, input bit push,
                       input logic [15:0] ew, input logic en, input logic es,
                       input bit tare_last);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ad_valid = 1'b1;
      ad_data  = d;
      tare_req = tare_last && (i == n - 1);
      if (push && (i == n - 1)) begin
        exp_t e;
        e.w   = ew;
        e.neg = en;
        e.st  = es;
        e.cyc = cyc + 4;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      ad_valid = 1'b0;
      tare_req = 1'b0;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: got %0d outputs pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs += 5;
    if (weight !== 16'd0) begin
      errs++; $display("FAIL reset_weight: got %0d, required 0", weight);
    end
    if (weight_valid !== 1'b0) begin
      errs++; $display("FAIL reset_valid: got %0b, required 0", weight_valid);
    end
    if (weight_neg !== 1'b0) begin
      errs++; $display("FAIL reset_neg: got %0b, required 0", weight_neg);
    end
    if (weight_stable !== 1'b0) begin
      errs++; $display("FAIL reset_stable: got %0b, required 0", weight_stable);
    end
    if (tare_busy !== 1'b0) begin
      errs++; $display("FAIL reset_tare_busy: got %0b, required 0", tare_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    drive(24'd1000, 8, 1'b1, 16'd1000, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  // Tare requested with a completing sample: that block is measured, the next one tares.
  task automatic test_tare();
    drive(24'd1000, 8, 1'b1, 16'd1000, 1'b0, 1'b0, 1'b1);
    vecs++;
    if (tare_busy !== 1'b1) begin
      errs++; $display("FAIL tare_busy_set: got %0b, required 1", tare_busy);
    end
    drive(24'd1000, 8, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    drain();
    vecs++;
    if (tare_busy !== 1'b0) begin
      errs++; $display("FAIL tare_busy_clear: got %0b, required 0", tare_busy);
    end
    drive(24'd5219, 8, 1'b1, 16'd4219, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_negative();
    drive(24'd62, 8, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_clamp();
    apply_reset();
    drive(24'h7FFFFF, 8, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    drive(24'hFFFFFF, 8, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_reset_midblock();
    drive(24'd1000, 5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    apply_reset();
    drive(24'd5219, 8, 1'b1, 16'd5219, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_stable();
    apply_reset();
    for (int b = 0; b < 5; b++) begin
      drive(24'd1000, 8, 1'b1, 16'd1000, 1'b0, (b == 4) ? StabEn : 1'b0, 1'b0);
    end
    drive(24'd2000, 8, 1'b1, 16'd2000, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tare();
    test_negative();
    test_clamp();
    test_reset_midblock();
    test_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
